// File: rtl/awm_pkg.sv
// Shared types for the automatic washing machine controller.
// Binary state encoding; codes 6 and 7 are unused and recover to CHECK_DOOR.
package awm_pkg;

  typedef enum logic [2:0] {
    CHECK_DOOR    = 3'd0,
    FILL_WATER    = 3'd1,
    ADD_DETERGENT = 3'd2,
    WASH_CYCLE    = 3'd3,
    DRAIN_WATER   = 3'd4,
    SPIN          = 3'd5
  } state_e;

endpackage

// File: rtl/automatic_washing_machine.sv
// Program sequencer for a front-loading washer: soap pass, rinse pass, spin.
// Purely control; all phase durations come from external sensors and timers.
module automatic_washing_machine
  import awm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic door_close,
  input  logic start,
  input  logic filled,
  input  logic detergent_added,
  input  logic cycle_timeout,
  input  logic drained,
  input  logic spin_timeout,
  output logic door_lock,
  output logic motor_on,
  output logic fill_value_on,
  output logic drain_value_on,
  output logic done,
  output logic soap_wash,
  output logic water_wash
);

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   soap_q, soap_d;
  logic   water_q, water_d;

  // The pass flags decide whether a fill/drain belongs to the soap or rinse pass.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    soap_d  = soap_q;
    water_d = water_q;
    case (state_q)
      CHECK_DOOR: begin
        if (start && door_close) begin
          state_d = FILL_WATER;
          done_d  = 1'b0;
          soap_d  = 1'b0;
          water_d = 1'b0;
        end
      end
      FILL_WATER: begin
        if (filled && !soap_q) begin
          state_d = ADD_DETERGENT;
          soap_d  = 1'b1;
        end else if (filled && soap_q) begin
          state_d = WASH_CYCLE;
        end
      end
      ADD_DETERGENT: begin
        if (detergent_added) state_d = WASH_CYCLE;
      end
      WASH_CYCLE: begin
        if (cycle_timeout) state_d = DRAIN_WATER;
      end
      DRAIN_WATER: begin
        if (drained && !water_q) begin
          state_d = FILL_WATER;
          water_d = 1'b1;
        end else if (drained && water_q) begin
          state_d = SPIN;
        end
      end
      SPIN: begin
        if (spin_timeout) begin
          state_d = CHECK_DOOR;
          done_d  = 1'b1;
          soap_d  = 1'b0;
          water_d = 1'b0;
        end
      end
      default: begin
        state_d = CHECK_DOOR;
        done_d  = 1'b0;
        soap_d  = 1'b0;
        water_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CHECK_DOOR;
      done_q  <= 1'b0;
      soap_q  <= 1'b0;
      water_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      soap_q  <= soap_d;
      water_q <= water_d;
    end
  end

  // Actuators decode straight from the state register so reset drops them at once.
  always_comb begin
    door_lock      = 1'b0;
    motor_on       = 1'b0;
    fill_value_on  = 1'b0;
    drain_value_on = 1'b0;
    case (state_q)
      FILL_WATER: begin
        door_lock     = 1'b1;
        fill_value_on = 1'b1;
      end
      ADD_DETERGENT: door_lock = 1'b1;
      WASH_CYCLE: begin
        door_lock = 1'b1;
        motor_on  = 1'b1;
      end
      DRAIN_WATER: begin
        door_lock      = 1'b1;
        drain_value_on = 1'b1;
      end
      SPIN: begin
        door_lock      = 1'b1;
        motor_on       = 1'b1;
        drain_value_on = 1'b1;
      end
      default: ;
    endcase
  end

  assign done       = done_q;
  assign soap_wash  = soap_q;
  assign water_wash = water_q;

endmodule

// File: tb/tb_automatic_washing_machine.sv
// Self-checking bench: a step-indexed program model predicts all seven outputs
// each cycle, under directed scenarios and randomized sensor levels.
module tb_automatic_washing_machine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic door_close = 1'b0;
  logic start = 1'b0;
  logic filled = 1'b0;
  logic detergent_added = 1'b0;
  logic cycle_timeout = 1'b0;
  logic drained = 1'b0;
  logic spin_timeout = 1'b0;
  logic door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash;

  automatic_washing_machine dut (
    .clk(clk),
    .reset(reset),
    .door_close(door_close),
    .start(start),
    .filled(filled),
    .detergent_added(detergent_added),
    .cycle_timeout(cycle_timeout),
    .drained(drained),
    .spin_timeout(spin_timeout),
    .door_lock(door_lock),
    .motor_on(motor_on),
    .fill_value_on(fill_value_on),
    .drain_value_on(drain_value_on),
    .done(done),
    .soap_wash(soap_wash),
    .water_wash(water_wash)
  );

  always #5 clk = ~clk;

  wire [6:0] obs = {door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash};

  // The program is a fixed list of phases; the model only tracks its position in it.
  typedef enum int {P_FILL, P_DET, P_WASH, P_DRAIN, P_SPIN} phase_t;
  phase_t prog [8] = '{P_FILL, P_DET, P_WASH, P_DRAIN, P_FILL, P_WASH, P_DRAIN, P_SPIN};
  int mStep = -1;
  bit mDone = 1'b0;
  int nCompared = 0;
  int nMismatched = 0;

  function automatic bit phaseSensor(phase_t p);
    case (p)
      P_FILL:  return filled;
      P_DET:   return detergent_added;
      P_WASH:  return cycle_timeout;
      P_DRAIN: return drained;
      default: return spin_timeout;
    endcase
  endfunction

  // Expected order: door_lock, motor_on, fill, drain, done, soap_wash, water_wash.
  function automatic logic [6:0] modelOutputs();
    phase_t p;
    if (mStep < 0) return {4'b0000, mDone, 2'b00};
    p = prog[mStep];
    return {1'b1, (p == P_WASH || p == P_SPIN), (p == P_FILL),
            (p == P_DRAIN || p == P_SPIN), 1'b0, (mStep >= 1), (mStep >= 4)};
  endfunction

  task automatic modelEdge();
    if (reset) begin
      mStep = -1;
      mDone = 1'b0;
    end else if (mStep < 0) begin
      if (start && door_close) begin
        mStep = 0;
        mDone = 1'b0;
      end
    end else if (phaseSensor(prog[mStep])) begin
      mStep++;
      if (mStep == 8) begin
        mStep = -1;
        mDone = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  // Inputs in order: door_close, start, filled, detergent_added, cycle_timeout, drained, spin_timeout.
  task automatic applyStimulus(input logic [6:0] v);
    {door_close, start, filled, detergent_added, cycle_timeout, drained, spin_timeout} = v;
  endtask

  task automatic goIdle();
    reset = 1'b1;
    applyStimulus(7'b0);
    #2;
    mStep = -1;
    mDone = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(7'($urandom));
      tick();
      nCompared++;
      if (obs !== modelOutputs()) begin
        nMismatched++;
        $display("[TB] FAIL reset_hold cycle %0d: got %b expected %b", i, obs, modelOutputs());
      end
    end
    goIdle();
  endtask

  task automatic test_door_interlock();
    goIdle();
    applyStimulus(7'b0100000);
    for (int i = 0; i < 5; i++) begin
      tick();
      nCompared++;
      if (obs !== modelOutputs() || door_lock !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL door_open_ignored cycle %0d: got %b expected %b", i, obs, modelOutputs());
      end
    end
    applyStimulus(7'b1100000);
    tick();
    nCompared++;
    if (obs !== modelOutputs() || {door_lock, fill_value_on} !== 2'b11) begin
      nMismatched++;
      $display("[TB] FAIL door_closed_start: got %b expected %b", obs, modelOutputs());
    end
  endtask

  task automatic test_full_program();
    logic [6:0] v;
    goIdle();
    v = 7'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) v = 7'b1100000;
      else if (i <= 5) v[6-(i+1)] = 1'b1;
      applyStimulus(v);
      tick();
      nCompared++;
      if (obs !== modelOutputs()) begin
        nMismatched++;
        $display("[TB] FAIL full_program edge %0d: got %b expected %b", i + 1, obs, modelOutputs());
      end
    end
  endtask

  task automatic test_all_high();
    int edges;
    goIdle();
    applyStimulus(7'b1111111);
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      edges++;
      nCompared++;
      if (obs !== modelOutputs()) begin
        nMismatched++;
        $display("[TB] FAIL all_high edge %0d: got %b expected %b", edges, obs, modelOutputs());
      end
      if (done === 1'b1) break;
    end
    nCompared++;
    if (edges !== 9 || done !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL all_high_latency: got %0d edges (done=%b) expected 9 edges", edges, done);
    end
  endtask

  task automatic test_fill_hold();
    goIdle();
    applyStimulus(7'b1100000);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(7'($urandom) & 7'b1101111);
      tick();
      nCompared++;
      if (obs !== modelOutputs() || {door_lock, fill_value_on, motor_on} !== 3'b110) begin
        nMismatched++;
        $display("[TB] FAIL fill_hold cycle %0d: got %b expected %b", i, obs, modelOutputs());
      end
    end
  endtask

  task automatic test_spin();
    goIdle();
    applyStimulus(7'b1111110);
    for (int i = 0; i < 8; i++) tick();
    nCompared++;
    if (obs !== modelOutputs() || {motor_on, drain_value_on} !== 2'b11) begin
      nMismatched++;
      $display("[TB] FAIL spin_entry: got %b expected %b", obs, modelOutputs());
    end
    #2;
    reset = 1'b1;
    #1;
    mStep = -1;
    mDone = 1'b0;
    nCompared++;
    if (obs !== modelOutputs()) begin
      nMismatched++;
      $display("[TB] FAIL reset_mid_spin: got %b expected %b", obs, modelOutputs());
    end
    reset = 1'b0;
    applyStimulus(7'b1111110);
    for (int i = 0; i < 8; i++) tick();
    applyStimulus(7'b1011111);
    tick();
    nCompared++;
    if (obs !== modelOutputs() || {door_lock, done} !== 2'b01) begin
      nMismatched++;
      $display("[TB] FAIL spin_done: got %b expected %b", obs, modelOutputs());
    end
    tick();
    nCompared++;
    if (obs !== modelOutputs()) begin
      nMismatched++;
      $display("[TB] FAIL done_held_idle: got %b expected %b", obs, modelOutputs());
    end
    applyStimulus(7'b1100000);
    tick();
    nCompared++;
    if (obs !== modelOutputs() || done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL restart_clears_done: got %b expected %b", obs, modelOutputs());
    end
  endtask

  task automatic test_random();
    goIdle();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      applyStimulus(7'($urandom) | {1'b0, 1'b0, 5'($urandom)});
      tick();
      nCompared++;
      if (obs !== modelOutputs()) begin
        nMismatched++;
        $display("[TB] FAIL random cycle %0d: got %b expected %b", i, obs, modelOutputs());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_door_interlock();
    test_full_program();
    test_all_high();
    test_fill_hold();
    test_spin();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
